// File: rtl/reg_file_rename.sv
// Architectural register file with rename busy/tag state; reads are combinational (0 cycles) with commit bypass.
// Commit/rename/flush update on the next edge; rdy=0 stalls all state, no internal backpressure.
module reg_file_rename #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rn_fg,
    input  logic [4:0]       rn_idx,
    input  logic [TAG_W-1:0] rn_tag,
    input  logic             cm_fg,
    input  logic [4:0]       cm_idx,
    input  logic [XLEN-1:0]  cm_val,
    input  logic [TAG_W-1:0] cm_tag,
    input  logic             flush,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic             rs1_ready,
    output logic             rs2_ready,
    output logic [XLEN-1:0]  rs1_val,
    output logic [XLEN-1:0]  rs2_val,
    output logic [5:0]       busy_cnt
);

    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [5:0]       busy_cnt_q;
    logic [5:0]       busy_cnt_d;

    logic cm_en;
    logic rn_en;
    logic cm_clr;
    logic rn_new;

    // A commit only releases the register if its tag still names the newest producer
    // and no rename of the same register lands in this cycle.
    always_comb begin
        cm_en  = rdy && cm_fg && (cm_idx != 5'd0);
        rn_en  = rdy && rn_fg && (rn_idx != 5'd0) && !flush;
        cm_clr = cm_en && busy_q[cm_idx] && (tag_q[cm_idx] == cm_tag)
                 && !(rn_fg && (rn_idx == cm_idx));
        rn_new = rn_en && !busy_q[rn_idx];
    end

    always_comb begin
        val_d      = val_q;
        tag_d      = tag_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (cm_en) begin
            val_d[cm_idx] = cm_val;
        end
        if (cm_clr) begin
            busy_d[cm_idx] = 1'b0;
        end
        if (rn_en) begin
            busy_d[rn_idx] = 1'b1;
            tag_d[rn_idx]  = rn_tag;
        end
        if (rdy && flush) begin
            busy_d     = '0;
            busy_cnt_d = '0;
        end else begin
            busy_cnt_d = busy_cnt_q + {5'd0, rn_new} - {5'd0, cm_clr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            val_q      <= val_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Returns {ready, value-or-tag}; a same-cycle rename deliberately plays no part here.
    function automatic logic [XLEN:0] read_port(input logic [4:0] addr);
        logic [XLEN:0] res;
        if (addr == 5'd0) begin
            res = '0;
            res[XLEN] = 1'b1;
        end else if (cm_fg && rdy && (cm_idx == addr) && busy_q[addr]
                     && (cm_tag == tag_q[addr])) begin
            res = {1'b1, cm_val};
        end else if (busy_q[addr]) begin
            res = {1'b0, {(XLEN-TAG_W){1'b0}}, tag_q[addr]};
        end else begin
            res = {1'b1, val_q[addr]};
        end
        return res;
    endfunction

    always_comb begin
        {rs1_ready, rs1_val} = read_port(rs1_addr);
        {rs2_ready, rs2_val} = read_port(rs2_addr);
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with rename status for the out-of-order core.
- Sits directly downstream of the reorder buffer: ROB commits write values here.
- Decode-time rename marks a destination register busy with its ROB tag.
- Serves operand reads back to the ROB issue logic: ready value, or producing ROB tag when busy.

Parameters:
- TAG_W, 4, ROB tag width (16-entry ROB)
- XLEN, 32, register data width
- NREG, 32, number of architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- rdy  in  1  global ready; when 0 all state holds
- rn_fg  in  1  rename request from issue this cycle
- rn_idx  in  5  destination register being renamed
- rn_tag  in  TAG_W  ROB entry (rear) allocated to that destination
- cm_fg  in  1  commit write from ROB head
- cm_idx  in  5  committed destination register
- cm_val  in  XLEN  committed value
- cm_tag  in  TAG_W  ROB entry (front) being committed
- flush  in  1  pipeline flush; clears all rename state
- rs1_addr, rs2_addr  in  5  source register addresses from decode
- rs1_ready, rs2_ready  out  1  operand value available
- rs1_val, rs2_val  out  XLEN  value if ready, else producing tag zero-extended to XLEN
- busy_cnt  out  6  number of registers currently busy (0..31)

Behaviour:
- State per register: val[XLEN], busy[1], tag[TAG_W]. x0: val=0, busy=0 permanently; rename/commit to x0 ignored.
- Reset (rst==0 at edge): all val=0, busy=0, tag=0, busy_cnt=0. Reset wins over every other input, including rdy=0.
- rdy==0 and rst==1: no state change; read outputs stay combinationally valid.
- Reads are combinational (0-cycle latency), priority order:
  - addr==0 -> ready=1, val=0.
  - Commit bypass: cm_fg && rdy && cm_idx==addr && cm_tag==tag[addr] && busy[addr] -> ready=1, val=cm_val.
  - Else if busy[addr] -> ready=0, val={0,tag[addr]}.
  - Else -> ready=1, val=val[addr].
  - A same-cycle rename never affects reads; it applies only to the next instruction.
- Commit, at edge when rdy && cm_fg && cm_idx!=0:
  - val[cm_idx] <= cm_val unconditionally.
  - busy[cm_idx] cleared only if busy && tag[cm_idx]==cm_tag && not (rn_fg && rn_idx==cm_idx). A stale tag means a younger producer still owns the register; busy is kept.
- Rename, at edge when rdy && rn_fg && rn_idx!=0 && !flush: busy[rn_idx] <= 1, tag[rn_idx] <= rn_tag. This overrides a same-cycle commit to the same register.
- Flush, at edge when rdy && flush:
  - All busy <= 0; tags retained but ignored.
  - Same-cycle rename is dropped.
  - Same-cycle commit value write still occurs.
- busy_cnt is a registered counter updated each edge: +1 for a rename of a not-busy register, -1 for a tag-matched clearing commit, net of both.
  - Re-renaming an already busy register: no change.
  - Flush: 0.
  - Must always equal the popcount of busy; bench checks this invariant.
- Boundary conditions:
  - Tag wrap: tags 15 -> 0 are just values; no ordering assumed.
  - Rename and commit of different registers in the same cycle are independent.
  - Two reads of the same address return identical results.

Test Plan:
- Reset then read x5 -> rs1_ready=1, rs1_val=0, busy_cnt=0. Write via commit cm_idx=5, cm_val=0x1234, cm_tag=0 while not busy -> next cycle read x5 = 0x1234, ready=1.
- Rename x3 with tag 7; next cycle read x3 -> ready=0, val=7, busy_cnt=1. Commit cm_idx=3, tag 7, val 0xAA -> same-cycle read ready=1, val=0xAA (bypass); next cycle busy_cnt=0.
- Stale commit: rename x4 tag 2, then rename x4 tag 9, then commit x4 tag 2 val 0x55 -> x4 still busy, val=9 reported, busy_cnt=1; commit tag 9 val 0x66 -> ready, 0x66.
- Same-cycle rename x6 tag 4 and commit x6 (old tag 1, val 0x10) -> after edge busy=1, tag=4, internal val 0x10; later commit tag 4 clears busy.
- Flush with x1, x2, x8 busy and a simultaneous rename of x9 -> all ready next cycle, x9 not busy, busy_cnt=0. Rename/commit to x0 -> x0 reads 0, ready=1, busy_cnt unchanged.
- rdy=0 with rn_fg/cm_fg asserted -> no state change. Drop rst to 0 with registers busy -> next cycle all values 0, all ready, busy_cnt=0.
